output_logic: RTL and testbench

Pixel write formatter for the 2D GPU frame-buffer path. It turns a 16-bit RGB565 colour and a halfword-select bit into a 32-bit replicated data word with matching byte enables, using a purely combinational path. It also provides a registered, single-outstanding Avalon-MM write command stage that presents the formatted word to the SRAM/frame-buffer interconnect.

---
 rtl/output_logic_pkg.sv | 20 ++
 rtl/output_logic_pixel_formatter.sv | 26 ++
 rtl/output_logic.sv | 90 +++++++++
 tb/tb_output_logic.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/output_logic_pkg.sv
// Shared GPU frame-buffer write definitions: lane enables, colour type, address width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package output_logic_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 32;

    // Halfword lane enables for a 32-bit frame-buffer word.
    localparam logic [3:0] BE_LOW  = 4'b0011;
    localparam logic [3:0] BE_HIGH = 4'b1100;

    // RGB565 pixel colour.
    typedef logic [15:0] color_t;

    // Lane enables that select the halfword addressed by address_lsb.
    function automatic logic [3:0] halfword_be(input logic address_lsb);
        return address_lsb ? BE_HIGH : BE_LOW;
    endfunction

endpackage

// File: rtl/output_logic_pixel_formatter.sv
// Replicates an RGB565 colour across both halfwords of a 32-bit word and selects lane enables.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow color/address_lsb continuously.
//
// Ports:
//   color       - pixel colour
//   address_lsb - halfword select (0 = low, 1 = high)
//   pixel_data  - {color, color}
//   byteenable  - 4'b0011 for the low halfword, 4'b1100 for the high halfword
module pixel_formatter
    import output_logic_pkg::*;
(
    input  color_t      color,
    input  logic        address_lsb,
    output logic [31:0] pixel_data,
    output logic [3:0]  byteenable
);

    // Replicating the colour lets the interconnect pick either halfword purely by byteenable,
    // so no data shifting depends on the address.
    always_comb begin
        pixel_data = {color, color};
        byteenable = halfword_be(address_lsb);
    end

endmodule

// File: rtl/output_logic.sv
// Pixel write formatter plus single-outstanding registered Avalon-MM write command stage.
// Latency: formatting is combinational; accept-to-avm_write is one clock edge.
// Backpressure: write_ready drops while a write is stalled by avm_waitrequest; completion and a new accept may share an edge.
//
// Ports:
//   clk, rst                      - clock; synchronous active-high reset
//   color, address_lsb            - pixel colour and halfword select
//   pixel_data, byteenable        - combinational formatted word and lane enables
//   word_addr, write_req          - command address and request
//   write_ready                   - request accepted on this edge when write_req is high
//   avm_write, avm_address,
//   avm_writedata, avm_byteenable - registered Avalon-MM write command
//   avm_waitrequest               - slave stall
module output_logic
    import output_logic_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  color_t                color,
    input  logic                  address_lsb,
    output logic [31:0]           pixel_data,
    output logic [3:0]            byteenable,
    input  logic [ADDR_WIDTH-1:0] word_addr,
    input  logic                  write_req,
    output logic                  write_ready,
    output logic                  avm_write,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [31:0]           avm_writedata,
    output logic [3:0]            avm_byteenable,
    input  logic                  avm_waitrequest
);

    logic                  avm_write_q,      avm_write_d;
    logic [ADDR_WIDTH-1:0] avm_address_q,    avm_address_d;
    logic [31:0]           avm_writedata_q,  avm_writedata_d;
    logic [3:0]            avm_byteenable_q, avm_byteenable_d;
    logic                  accept;

    pixel_formatter u_pixel_formatter (
        .color       (color),
        .address_lsb (address_lsb),
        .pixel_data  (pixel_data),
        .byteenable  (byteenable)
    );

    // avm_write is the whole state: low = IDLE, high = BUSY. The slot frees up on the same
    // edge the slave takes the current command, which is what allows back-to-back writes.
    always_comb begin
        write_ready      = !avm_write_q || !avm_waitrequest;
        accept           = write_req && write_ready;

        avm_write_d      = avm_write_q;
        avm_address_d    = avm_address_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;

        if (accept) begin
            avm_write_d      = 1'b1;
            avm_address_d    = word_addr;
            avm_writedata_d  = pixel_data;
            avm_byteenable_d = byteenable;
        end else if (avm_write_q && !avm_waitrequest) begin
            // Transfer completes; payload registers keep their last value.
            avm_write_d      = 1'b0;
        end
    end

    // Reset wins over accept and completion, aborting any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            avm_write_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
        end else begin
            avm_write_q      <= avm_write_d;
            avm_address_q    <= avm_address_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
        end
    end

    assign avm_write      = avm_write_q;
    assign avm_address    = avm_address_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;

endmodule

// File: tb/tb_output_logic.sv
// Directed self-checking bench for output_logic: formatting, reset, single write, back-to-back, stall, mid-transfer reset.
// Latency: checks sampled 1 ns after each rising edge or input change.
// Backpressure: exercised by holding avm_waitrequest high with a pending write_req.
module tb_output_logic;

    logic        clk;
    logic        rst;
    logic [15:0] color;
    logic        address_lsb;
    logic [31:0] pixel_data;
    logic [3:0]  byteenable;
    logic [31:0] word_addr;
    logic        write_req;
    logic        write_ready;
    logic        avm_write;
    logic [31:0] avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Packed view of the registered command: {write, address, data, byteenable}.
    logic [68:0] got, exp;

    output_logic #(.ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .color           (color),
        .address_lsb     (address_lsb),
        .pixel_data      (pixel_data),
        .byteenable      (byteenable),
        .word_addr       (word_addr),
        .write_req       (write_req),
        .write_ready     (write_ready),
        .avm_write       (avm_write),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; write_req = 1'b0; avm_waitrequest = 1'b0;
        word_addr = 32'hDEAD_BEEF; color = 16'h1111; address_lsb = 1'b1;
        tick();
        tick();
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        exp = {1'b0, 32'h0, 32'h0, 4'h0};
        total_cnt++;
        if (got !== exp) $display("FAIL reset_regs: got %h expected %h", got, exp);
        else pass_cnt++;
        total_cnt++;
        if (write_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", write_ready);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_format();
        logic [15:0] colors [4];
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        colors[0] = 16'h5555; colors[1] = 16'hAAAA; colors[2] = 16'hFFFF; colors[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                color = colors[i];
                address_lsb = s[0];
                #1;
                exp_data = {colors[i], colors[i]};
                exp_be   = (s == 0) ? 4'b0011 : 4'b1100;
                total_cnt++;
                if (pixel_data !== exp_data)
                    $display("FAIL fmt_data c=%h lsb=%0d: got %h expected %h", colors[i], s, pixel_data, exp_data);
                else pass_cnt++;
                total_cnt++;
                if (byteenable !== exp_be)
                    $display("FAIL fmt_be c=%h lsb=%0d: got %b expected %b", colors[i], s, byteenable, exp_be);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_single_write();
        word_addr = 32'h100; color = 16'h1234; address_lsb = 1'b1;
        write_req = 1'b1; avm_waitrequest = 1'b0;
        #1;
        total_cnt++;
        if (write_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", write_ready);
        else pass_cnt++;
        tick();
        write_req = 1'b0;
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        exp = {1'b1, 32'h100, 32'h1234_1234, 4'b1100};
        total_cnt++;
        if (got !== exp) $display("FAIL single_issue: got %h expected %h", got, exp);
        else pass_cnt++;
        tick();
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        exp = {1'b0, 32'h100, 32'h1234_1234, 4'b1100};
        total_cnt++;
        if (got !== exp) $display("FAIL single_complete: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        avm_waitrequest = 1'b0;
        word_addr = 32'h180; color = 16'hC0DE; address_lsb = 1'b0; write_req = 1'b1;
        tick();
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        exp = {1'b1, 32'h180, 32'hC0DE_C0DE, 4'b0011};
        total_cnt++;
        if (got !== exp) $display("FAIL b2b_first: got %h expected %h", got, exp);
        else pass_cnt++;
        word_addr = 32'h184; color = 16'hBEEF; address_lsb = 1'b1;
        tick();
        write_req = 1'b0;
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        exp = {1'b1, 32'h184, 32'hBEEF_BEEF, 4'b1100};
        total_cnt++;
        if (got !== exp) $display("FAIL b2b_second: got %h expected %h", got, exp);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (avm_write !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", avm_write);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        word_addr = 32'h200; color = 16'hABCD; address_lsb = 1'b0;
        write_req = 1'b1; avm_waitrequest = 1'b1;
        tick();
        // Second command waits behind the stalled first one.
        word_addr = 32'h300; color = 16'h0F0F; address_lsb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if (write_ready !== 1'b0) $display("FAIL stall_ready cyc=%0d: got %b expected 0", c, write_ready);
            else pass_cnt++;
            got = {avm_write, avm_address, avm_writedata, avm_byteenable};
            exp = {1'b1, 32'h200, 32'hABCD_ABCD, 4'b0011};
            total_cnt++;
            if (got !== exp) $display("FAIL stall_hold cyc=%0d: got %h expected %h", c, got, exp);
            else pass_cnt++;
            tick();
        end
        avm_waitrequest = 1'b0;
        #1;
        total_cnt++;
        if (write_ready !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", write_ready);
        else pass_cnt++;
        tick();
        write_req = 1'b0;
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        exp = {1'b1, 32'h300, 32'h0F0F_0F0F, 4'b1100};
        total_cnt++;
        if (got !== exp) $display("FAIL stall_second: got %h expected %h", got, exp);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (avm_write !== 1'b0) $display("FAIL stall_done: got %b expected 0", avm_write);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        word_addr = 32'h400; color = 16'h7777; address_lsb = 1'b0;
        write_req = 1'b1; avm_waitrequest = 1'b1;
        tick();
        total_cnt++;
        if (avm_write !== 1'b1) $display("FAIL rstmid_busy: got %b expected 1", avm_write);
        else pass_cnt++;
        // Reset with waitrequest low and a fresh request: both completion and accept must lose.
        rst = 1'b1; avm_waitrequest = 1'b0;
        word_addr = 32'h500; color = 16'h9999; address_lsb = 1'b1;
        tick();
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        exp = 69'h0;
        total_cnt++;
        if (got !== exp) $display("FAIL rstmid_abort: got %h expected %h", got, exp);
        else pass_cnt++;
        rst = 1'b0; write_req = 1'b0;
        tick();
        got = {avm_write, avm_address, avm_writedata, avm_byteenable};
        total_cnt++;
        if (got !== exp) $display("FAIL rstmid_after: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; color = '0; address_lsb = 1'b0; word_addr = '0;
        write_req = 1'b0; avm_waitrequest = 1'b0;
        test_reset();
        test_format();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
